// File: rtl/gpr_pkg.sv
// -----------------------------------------------------------------------------
// gpr_pkg
// Shared definitions for the gpr writeback path: architected widths of the
// gpr register file and the entry type carried through the writeback queue.
// -----------------------------------------------------------------------------
package gpr_pkg;

    localparam int GPR_DATA_W   = 16;
    localparam int GPR_SEL_W    = 4;
    localparam int GPR_NUM_REGS = 8;

    // One pending register write: destination select and value.
    typedef struct packed {
        logic [GPR_SEL_W-1:0]  sel;
        logic [GPR_DATA_W-1:0] data;
    } wb_entry_t;

endpackage : gpr_pkg

// File: rtl/gpr_writeback_if.sv
// -----------------------------------------------------------------------------
// gpr_writeback_if
// Producer-side handshake bundle for the writeback stage: one valid/ready
// channel from the ALU and one from the memory unit, each carrying a
// destination select and a result value.
//   master : producer view (drives valid/sel/data, receives ready)
//   slave  : writeback stage view (receives valid/sel/data, drives ready)
// -----------------------------------------------------------------------------
interface gpr_writeback_if
    import gpr_pkg::*;
#(
    parameter int DATA_W = GPR_DATA_W,
    parameter int SEL_W  = GPR_SEL_W
);

    logic              alu_valid;
    logic              alu_ready;
    logic [SEL_W-1:0]  alu_sel;
    logic [DATA_W-1:0] alu_data;

    logic              mem_valid;
    logic              mem_ready;
    logic [SEL_W-1:0]  mem_sel;
    logic [DATA_W-1:0] mem_data;

    modport master (
        output alu_valid, alu_sel, alu_data,
        output mem_valid, mem_sel, mem_data,
        input  alu_ready, mem_ready
    );

    modport slave (
        input  alu_valid, alu_sel, alu_data,
        input  mem_valid, mem_sel, mem_data,
        output alu_ready, mem_ready
    );

endinterface : gpr_writeback_if

// File: rtl/gpr_writeback_fifo.sv
// -----------------------------------------------------------------------------
// wb_fifo
// In-order DEPTH-entry queue of wb_entry_t with two ordered push ports and one
// pop port. push_a is always enqueued ahead of push_b when both fire on the
// same edge. The caller guarantees there is room for every push it issues.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   push_a, push_a_entry  : older push of the cycle
//   push_b, push_b_entry  : younger push of the cycle
//   pop                   : remove head (ignored when empty)
//   head                  : entry at the read pointer
//   count                 : occupancy, 0..DEPTH
//   entry_valid, entries  : per-slot occupancy flags and slot contents
// -----------------------------------------------------------------------------
module wb_fifo
    import gpr_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_a,
    input  wb_entry_t        push_a_entry,
    input  logic             push_b,
    input  wb_entry_t        push_b_entry,
    input  logic             pop,
    output wb_entry_t        head,
    output logic [CNT_W-1:0] count,
    output logic [DEPTH-1:0] entry_valid,
    output wb_entry_t        entries [DEPTH]
);

    wb_entry_t        slots_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;

    logic [PTR_W-1:0] b_slot_s;
    logic [1:0]       push_cnt_s;
    logic             do_pop_s;
    logic [PTR_W-1:0] off_s;

    // Slot for the younger push and the per-edge push/pop amounts.
    always_comb begin
        if (push_a) begin
            b_slot_s = wr_ptr_r + PTR_W'(1);
        end else begin
            b_slot_s = wr_ptr_r;
        end
        push_cnt_s = {1'b0, push_a} + {1'b0, push_b};
        do_pop_s   = pop && (count_r != CNT_W'(0));
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= PTR_W'(0);
            rd_ptr_r <= PTR_W'(0);
            count_r  <= CNT_W'(0);
        end else begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(push_cnt_s);
            rd_ptr_r <= rd_ptr_r + PTR_W'(do_pop_s);
            count_r  <= count_r + CNT_W'(push_cnt_s) - CNT_W'(do_pop_s);
        end
    end

    // Slot storage; contents only matter while the slot is counted valid.
    always_ff @(posedge clk) begin
        if (!reset && push_a) begin
            slots_r[wr_ptr_r] <= push_a_entry;
        end
        if (!reset && push_b) begin
            slots_r[b_slot_s] <= push_b_entry;
        end
    end

    // A slot is occupied when its distance from the read pointer is below count.
    always_comb begin
        entry_valid = {DEPTH{1'b0}};
        off_s       = {PTR_W{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            off_s          = PTR_W'(i) - rd_ptr_r;
            entry_valid[i] = ({1'b0, off_s} < count_r);
        end
    end

    assign head    = slots_r[rd_ptr_r];
    assign count   = count_r;
    assign entries = slots_r;

endmodule : wb_fifo

// File: rtl/gpr_writeback.sv
// -----------------------------------------------------------------------------
// gpr_writeback
// Writeback stage feeding the gpr register file. Accepts results from the ALU
// and memory unit, drops writes to non-existent registers, queues the rest in
// acceptance order and retires one per cycle on the registered wb_* port.
// pend_mask flags every register with a write queued or currently presented,
// for read-after-write hazard detection in decode.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   prod       : producer handshakes (ALU and memory), slave view
//   wb_load    : gpr load
//   wb_sel     : gpr write_select
//   wb_data    : gpr d_in
//   pend_mask  : per-register pending-write flags
//   count      : queue occupancy
// -----------------------------------------------------------------------------
module gpr_writeback
    import gpr_pkg::*;
#(
    parameter  int DATA_W   = GPR_DATA_W,
    parameter  int SEL_W    = GPR_SEL_W,
    parameter  int NUM_REGS = GPR_NUM_REGS,
    parameter  int DEPTH    = 4,
    localparam int CNT_W    = $clog2(DEPTH) + 1
) (
    input  logic                clk,
    input  logic                reset,
    gpr_writeback_if.slave      prod,
    output logic                wb_load,
    output logic [SEL_W-1:0]    wb_sel,
    output logic [DATA_W-1:0]   wb_data,
    output logic [NUM_REGS-1:0] pend_mask,
    output logic [CNT_W-1:0]    count
);

    localparam logic [SEL_W:0] NUM_REGS_X = (SEL_W + 1)'(NUM_REGS);

    logic                mem_ready_s;
    logic                alu_ready_s;
    logic                mem_push_s;
    logic                alu_push_s;
    logic                pop_s;
    wb_entry_t           mem_entry_s;
    wb_entry_t           alu_entry_s;
    wb_entry_t           head_s;
    logic [CNT_W-1:0]    count_s;
    logic [DEPTH-1:0]    entry_valid_s;
    wb_entry_t           entries_s [DEPTH];
    logic [NUM_REGS-1:0] pend_mask_s;

    logic                wb_load_r;
    logic [SEL_W-1:0]    wb_sel_r;
    logic [DATA_W-1:0]   wb_data_r;

    function automatic logic [NUM_REGS-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
        logic [NUM_REGS-1:0] oh;
        oh = {NUM_REGS{1'b0}};
        for (int r = 0; r < NUM_REGS; r++) begin
            oh[r] = (sel == SEL_W'(r));
        end
        return oh;
    endfunction

    // Ready depends only on pre-edge occupancy; ALU gets one slot of margin
    // so that a same-edge mem + ALU pair always fits without looking at pop.
    always_comb begin
        if (reset) begin
            mem_ready_s = 1'b0;
            alu_ready_s = 1'b0;
        end else begin
            mem_ready_s = (count_s < CNT_W'(DEPTH));
            alu_ready_s = (count_s <= CNT_W'(DEPTH - 2));
        end
    end

    assign prod.mem_ready = mem_ready_s;
    assign prod.alu_ready = alu_ready_s;

    // Completed handshakes to an out-of-range register are swallowed here.
    always_comb begin
        mem_push_s  = prod.mem_valid && mem_ready_s && ({1'b0, prod.mem_sel} < NUM_REGS_X);
        alu_push_s  = prod.alu_valid && alu_ready_s && ({1'b0, prod.alu_sel} < NUM_REGS_X);
        mem_entry_s = '{sel: prod.mem_sel, data: prod.mem_data};
        alu_entry_s = '{sel: prod.alu_sel, data: prod.alu_data};
        pop_s       = (count_s != CNT_W'(0));
    end

    // Memory result is the older of a same-edge pair, so it goes on port a.
    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk          (clk),
        .reset        (reset),
        .push_a       (mem_push_s),
        .push_a_entry (mem_entry_s),
        .push_b       (alu_push_s),
        .push_b_entry (alu_entry_s),
        .pop          (pop_s),
        .head         (head_s),
        .count        (count_s),
        .entry_valid  (entry_valid_s),
        .entries      (entries_s)
    );

    // Retire register: present the head for one cycle; sel/data hold when idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            wb_load_r <= 1'b0;
            wb_sel_r  <= SEL_W'(0);
            wb_data_r <= DATA_W'(0);
        end else if (pop_s) begin
            wb_load_r <= 1'b1;
            wb_sel_r  <= head_s.sel;
            wb_data_r <= head_s.data;
        end else begin
            wb_load_r <= 1'b0;
        end
    end

    // Pending writes: every occupied queue slot plus the write on the wb port.
    always_comb begin
        pend_mask_s = {NUM_REGS{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_valid_s[i]) begin
                pend_mask_s = pend_mask_s | sel_onehot(entries_s[i].sel);
            end else begin
                pend_mask_s = pend_mask_s;
            end
        end
        if (wb_load_r) begin
            pend_mask_s = pend_mask_s | sel_onehot(wb_sel_r);
        end else begin
            pend_mask_s = pend_mask_s;
        end
    end

    assign wb_load   = wb_load_r;
    assign wb_sel    = wb_sel_r;
    assign wb_data   = wb_data_r;
    assign pend_mask = pend_mask_s;
    assign count     = count_s;

endmodule : gpr_writeback

// File: tb/tb_gpr_writeback.sv
module tb_gpr_writeback;
    import gpr_pkg::*;

    localparam int DATA_W   = 16;
    localparam int SEL_W    = 4;
    localparam int NUM_REGS = 8;
    localparam int DEPTH    = 4;
    localparam int CNT_W    = 3;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                wb_load;
    logic [SEL_W-1:0]    wb_sel;
    logic [DATA_W-1:0]   wb_data;
    logic [NUM_REGS-1:0] pend_mask;
    logic [CNT_W-1:0]    count;

    gpr_writeback_if #(.DATA_W(DATA_W), .SEL_W(SEL_W)) bus ();

    gpr_writeback #(
        .DATA_W   (DATA_W),
        .SEL_W    (SEL_W),
        .NUM_REGS (NUM_REGS),
        .DEPTH    (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .prod      (bus),
        .wb_load   (wb_load),
        .wb_sel    (wb_sel),
        .wb_data   (wb_data),
        .pend_mask (pend_mask),
        .count     (count)
    );

    always #5 clk = ~clk;

    // Reference model: a plain FIFO of accepted writes plus the presented write.
    typedef struct {
        logic [SEL_W-1:0]  sel;
        logic [DATA_W-1:0] data;
    } wr_t;

    wr_t               mq[$];
    wr_t               sb[$];
    bit                m_load;
    logic [SEL_W-1:0]  m_sel;
    logic [DATA_W-1:0] m_data;
    logic [DATA_W-1:0] gpr_tb [16];
    int                checks = 0;
    int                errors = 0;
    bit                chk_model = 1'b0;
    int                acc_cnt = 0;
    logic              dut_mr;
    logic              dut_ar;

    typedef struct {
        bit               rst;
        bit               mv;
        logic [3:0]       msel;
        logic [15:0]      mdat;
        bit               av;
        logic [3:0]       asel;
        logic [15:0]      adat;
        bit               e_mr;
        bit               e_ar;
        bit               e_load;
        logic [3:0]       e_sel;
        logic [15:0]      e_data;
        logic [2:0]       e_cnt;
        logic [7:0]       e_pend;
    } vec_t;

    vec_t vec [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] model_pend();
        logic [7:0] m;
        m = 8'h00;
        foreach (mq[i]) m = m | (8'h01 << mq[i].sel);
        if (m_load) m = m | (8'h01 << m_sel);
        return m;
    endfunction

    task automatic drive(input bit mv, input logic [3:0] ms, input logic [15:0] md,
                         input bit av, input logic [3:0] as_, input logic [15:0] ad);
        bus.mem_valid = mv;
        bus.mem_sel   = ms;
        bus.mem_data  = md;
        bus.alu_valid = av;
        bus.alu_sel   = as_;
        bus.alu_data  = ad;
    endtask

    // One clock: sample pre-edge, advance the model, sample post-edge.
    task automatic tick();
        int  c;
        bit  mr;
        bit  ar;
        wr_t e;
        #1;
        c      = mq.size();
        mr     = !reset && (c < DEPTH);
        ar     = !reset && (c <= DEPTH - 2);
        dut_mr = bus.mem_ready;
        dut_ar = bus.alu_ready;
        if (chk_model) begin
            chk("mem_ready", dut_mr, mr);
            chk("alu_ready", dut_ar, ar);
        end
        if (wb_load === 1'b1) begin
            gpr_tb[wb_sel] = wb_data;
            chk("sb_nonempty", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("sb_sel", wb_sel, e.sel);
                chk("sb_data", wb_data, e.data);
            end
        end
        if (reset) begin
            mq.delete();
            sb.delete();
            m_load = 1'b0;
            m_sel  = '0;
            m_data = '0;
        end else begin
            if (c > 0) begin
                e      = mq.pop_front();
                m_load = 1'b1;
                m_sel  = e.sel;
                m_data = e.data;
            end else begin
                m_load = 1'b0;
            end
            if (bus.mem_valid && mr && bus.mem_sel < NUM_REGS) begin
                e = '{bus.mem_sel, bus.mem_data};
                mq.push_back(e);
                sb.push_back(e);
                acc_cnt++;
            end
            if (bus.alu_valid && ar && bus.alu_sel < NUM_REGS) begin
                e = '{bus.alu_sel, bus.alu_data};
                mq.push_back(e);
                sb.push_back(e);
                acc_cnt++;
            end
        end
        @(posedge clk);
        #1;
        if (chk_model) begin
            chk("wb_load", wb_load, m_load);
            chk("wb_sel", wb_sel, m_sel);
            chk("wb_data", wb_data, m_data);
            chk("count", count, mq.size());
            chk("pend_mask", pend_mask, model_pend());
        end
    endtask

    initial begin
        int acc0;
        int n;
        for (int r = 0; r < 16; r++) gpr_tb[r] = '0;
        drive(0, 0, 0, 0, 0, 0);

        //                rst mv msel mdat     av asel adat  mr ar ld sel data     cnt pend
        vec[0]  = '{1'b1, 0, 0,  16'd0,    0, 0, 16'd0, 0, 0, 0, 0, 16'd0,    0, 8'h00};
        vec[1]  = '{1'b0, 0, 0,  16'd0,    1, 2, 16'd23,1, 1, 0, 0, 16'd0,    1, 8'h04};
        vec[2]  = '{1'b0, 0, 0,  16'd0,    0, 0, 16'd0, 1, 1, 1, 2, 16'd23,   0, 8'h04};
        vec[3]  = '{1'b0, 0, 0,  16'd0,    0, 0, 16'd0, 1, 1, 0, 2, 16'd23,   0, 8'h00};
        vec[4]  = '{1'b0, 1, 6,  16'd18,   1, 0, 16'd23,1, 1, 0, 2, 16'd23,   2, 8'h41};
        vec[5]  = '{1'b0, 0, 0,  16'd0,    0, 0, 16'd0, 1, 1, 1, 6, 16'd18,   1, 8'h41};
        vec[6]  = '{1'b0, 0, 0,  16'd0,    0, 0, 16'd0, 1, 1, 1, 0, 16'd23,   0, 8'h01};
        vec[7]  = '{1'b0, 0, 0,  16'd0,    0, 0, 16'd0, 1, 1, 0, 0, 16'd23,   0, 8'h00};
        vec[8]  = '{1'b0, 0, 0,  16'd0,    1, 9, 16'd5, 1, 1, 0, 0, 16'd23,   0, 8'h00};
        vec[9]  = '{1'b0, 1, 15, 16'd7,    1, 8, 16'd1, 1, 1, 0, 0, 16'd23,   0, 8'h00};
        vec[10] = '{1'b0, 1, 7,  16'hBEEF, 0, 0, 16'd0, 1, 1, 0, 0, 16'd23,   1, 8'h80};
        vec[11] = '{1'b0, 0, 0,  16'd0,    0, 0, 16'd0, 1, 1, 1, 7, 16'hBEEF, 0, 8'h80};
        vec[12] = '{1'b0, 0, 0,  16'd0,    0, 0, 16'd0, 1, 1, 0, 7, 16'hBEEF, 0, 8'h00};

        for (int i = 0; i < 13; i++) begin
            reset = vec[i].rst;
            drive(vec[i].mv, vec[i].msel, vec[i].mdat, vec[i].av, vec[i].asel, vec[i].adat);
            tick();
            chk($sformatf("vec%0d_mem_ready", i), dut_mr, vec[i].e_mr);
            chk($sformatf("vec%0d_alu_ready", i), dut_ar, vec[i].e_ar);
            chk($sformatf("vec%0d_load", i), wb_load, vec[i].e_load);
            chk($sformatf("vec%0d_sel", i), wb_sel, vec[i].e_sel);
            chk($sformatf("vec%0d_data", i), wb_data, vec[i].e_data);
            chk($sformatf("vec%0d_count", i), count, vec[i].e_cnt);
            chk($sformatf("vec%0d_pend", i), pend_mask, vec[i].e_pend);
        end
        drive(0, 0, 0, 0, 0, 0);
        chk_model = 1'b1;

        // Continuous dual-producer pressure until 20 writes are accepted.
        acc0 = acc_cnt;
        n    = 0;
        while ((acc_cnt - acc0) < 20 && n < 100) begin
            drive(1, 4'($urandom_range(0, 7)), 16'($urandom),
                  1, 4'($urandom_range(0, 7)), 16'($urandom));
            tick();
            n++;
        end
        chk("fill_budget", (acc_cnt - acc0) >= 20, 1);
        drive(0, 0, 0, 0, 0, 0);
        repeat (6) tick();
        chk("fill_sb_drained", sb.size(), 0);
        chk("fill_count_empty", count, 0);

        // Reset with three writes queued: none of them may reach the gpr.
        gpr_tb[2] = 16'hDEAD;
        gpr_tb[3] = 16'hDEAD;
        gpr_tb[4] = 16'hDEAD;
        drive(1, 1, 16'd11, 1, 2, 16'd22);
        tick();
        drive(1, 3, 16'd33, 1, 4, 16'd44);
        tick();
        chk("pre_rst_count", count, 3);
        drive(0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_count", count, 0);
        chk("rst_load", wb_load, 0);
        chk("rst_pend", pend_mask, 0);
        repeat (4) begin
            tick();
            chk("post_rst_load", wb_load, 0);
        end
        chk("post_rst_gpr2", gpr_tb[2], 16'hDEAD);
        chk("post_rst_gpr3", gpr_tb[3], 16'hDEAD);
        chk("post_rst_gpr4", gpr_tb[4], 16'hDEAD);

        // Two writes to r3: the later value must win, bit 3 pending throughout.
        drive(1, 3, 16'd100, 0, 0, 0);
        tick();
        chk("same_reg_pend_a", pend_mask[3], 1);
        drive(0, 0, 0, 1, 3, 16'd200);
        tick();
        chk("same_reg_pend_b", pend_mask[3], 1);
        drive(0, 0, 0, 0, 0, 0);
        tick();
        chk("same_reg_pend_c", pend_mask[3], 1);
        chk("same_reg_second", wb_data, 16'd200);
        tick();
        chk("same_reg_pend_clear", pend_mask[3], 0);
        chk("same_reg_gpr3", gpr_tb[3], 16'd200);

        // Random traffic including illegal selects and occasional resets.
        for (int k = 0; k < 400; k++) begin
            reset = ($urandom_range(0, 49) == 0);
            drive($urandom_range(0, 3) != 0, 4'($urandom_range(0, 9)), 16'($urandom),
                  $urandom_range(0, 3) != 0, 4'($urandom_range(0, 9)), 16'($urandom));
            tick();
        end
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        repeat (6) tick();
        chk("final_sb_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_gpr_writeback
